// File: rtl/param_stack.sv
// Parametrised LIFO stack with status, error flags, a registered read strobe and replace-top.
// Build option STACK_STICKY_ERR_EN: overflow/underflow latch until reset instead of pulsing.
module param_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d_in,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    output logic [DATA_W-1:0] d_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Strobe protocol: push/pop/tos are single-cycle requests sampled on every
    // rising edge; there is no back-pressure. Results appear one cycle later and
    // valid_out is high for exactly the cycle in which d_out was refreshed.

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] d_out_q, d_out_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              is_empty, is_full;
    logic [CNT_W-1:0]  cnt_m1;
    logic [AW-1:0]     top_addr;
    logic [AW-1:0]     push_addr;
    logic [DATA_W-1:0] top_data;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              ovf_evt, unf_evt;

    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == DEPTH_C);
        cnt_m1    = count_q - ONE_C;
        top_addr  = cnt_m1[AW-1:0];
        push_addr = count_q[AW-1:0];
        // Asynchronous array read: a push in one cycle is visible to a pop/tos in the next.
        top_data  = mem_q[top_addr];

        count_d   = count_q;
        d_out_d   = d_out_q;
        valid_d   = 1'b0;
        ovf_evt   = 1'b0;
        unf_evt   = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = push_addr;
        mem_wdata = d_in;

        case ({push, pop})
            2'b00: begin
                if (tos) begin
                    if (is_empty) begin
                        unf_evt = 1'b1;
                    end else begin
                        d_out_d = top_data;
                        valid_d = 1'b1;
                    end
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    d_out_d = top_data;
                    valid_d = 1'b1;
                    count_d = cnt_m1;
                end
            end
            2'b10: begin
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    mem_we  = 1'b1;
                    count_d = count_q + ONE_C;
                end
            end
            default: begin
                // Replace-top; on an empty stack the incoming word bypasses straight to d_out.
                valid_d = 1'b1;
                if (is_empty) begin
                    d_out_d = d_in;
                end else begin
                    d_out_d   = top_data;
                    mem_we    = 1'b1;
                    mem_waddr = top_addr;
                end
            end
        endcase

`ifdef STACK_STICKY_ERR_EN
        ovf_d = ovf_q | ovf_evt;
        unf_d = unf_q | unf_evt;
`else
        ovf_d = ovf_evt;
        unf_d = unf_evt;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign d_out     = d_out_q;
    assign valid_out = valid_q;
    assign count     = count_q;
    assign full      = (count_q == DEPTH_C);
    assign empty     = (count_q == '0);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at DATA_W=8, DEPTH=4; honours STACK_STICKY_ERR_EN.
module tb_param_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef STACK_STICKY_ERR_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] d_in = '0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              tos = 1'b0;
    logic [DATA_W-1:0] d_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    int n_checks = 0;
    int n_errors = 0;
    bit lat_ovf = 1'b0;
    bit lat_unf = 1'b0;

    param_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .push(push), .pop(pop), .tos(tos),
        .d_out(d_out), .valid_out(valid_out), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one request for one edge, then return inputs to idle.
    task automatic op(input logic p, input logic q, input logic t, input logic [DATA_W-1:0] din);
        @(negedge clk);
        push = p; pop = q; tos = t; d_in = din;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; tos = 1'b0; d_in = '0;
    endtask

    task automatic expect_st(input string tag, input logic [DATA_W-1:0] e_dout, input logic e_valid,
                             input int e_cnt, input bit ovf_evt, input bit unf_evt);
        lat_ovf = lat_ovf | ovf_evt;
        lat_unf = lat_unf | unf_evt;
        check({tag, "_dout"},  32'(d_out), 32'(e_dout));
        check({tag, "_valid"}, 32'(valid_out), 32'(e_valid));
        check({tag, "_count"}, 32'(count), 32'(e_cnt));
        check({tag, "_full"},  32'(full), 32'(e_cnt == DEPTH));
        check({tag, "_empty"}, 32'(empty), 32'(e_cnt == 0));
        check({tag, "_ovf"},   32'(overflow), 32'(STICKY ? lat_ovf : ovf_evt));
        check({tag, "_unf"},   32'(underflow), 32'(STICKY ? lat_unf : unf_evt));
    endtask

    initial begin
        #2;
        expect_st("reset", 8'h00, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // LIFO order with back-to-back push then pop
        op(1, 0, 0, 8'h11); expect_st("p11", 8'h00, 0, 1, 0, 0);
        op(1, 0, 0, 8'h22); expect_st("p22", 8'h00, 0, 2, 0, 0);
        op(1, 0, 0, 8'h33); expect_st("p33", 8'h00, 0, 3, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("pop33", 8'h33, 1, 2, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("pop22", 8'h22, 1, 1, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("pop11", 8'h11, 1, 0, 0, 0);

        // Fill to DEPTH, overflow on the fifth push
        op(1, 0, 0, 8'hA0); expect_st("pA0", 8'h11, 0, 1, 0, 0);
        op(1, 0, 0, 8'hA1); expect_st("pA1", 8'h11, 0, 2, 0, 0);
        op(1, 0, 0, 8'hA2); expect_st("pA2", 8'h11, 0, 3, 0, 0);
        op(1, 0, 0, 8'hA3); expect_st("pA3", 8'h11, 0, 4, 0, 0);
        op(1, 0, 0, 8'hA4); expect_st("pA4_ovf", 8'h11, 0, 4, 1, 0);
        op(0, 0, 0, 8'h00); expect_st("idle_ovf", 8'h11, 0, 4, 0, 0);
        op(1, 1, 0, 8'hB3); expect_st("repl_full", 8'hA3, 1, 4, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("popB3", 8'hB3, 1, 3, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("popA2", 8'hA2, 1, 2, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("popA1", 8'hA1, 1, 1, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("popA0", 8'hA0, 1, 0, 0, 0);

        // Underflow on empty pop and tos
        op(0, 1, 0, 8'h00); expect_st("pop_empty", 8'hA0, 0, 0, 0, 1);
        op(0, 0, 1, 8'h00); expect_st("tos_empty", 8'hA0, 0, 0, 0, 1);
        op(1, 0, 0, 8'h01); expect_st("push_after_unf", 8'hA0, 0, 1, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("pop01", 8'h01, 1, 0, 0, 0);

        // Replace-top then tos
        op(1, 0, 0, 8'h05); expect_st("p05", 8'h01, 0, 1, 0, 0);
        op(1, 1, 0, 8'h09); expect_st("repl09", 8'h05, 1, 1, 0, 0);
        op(0, 0, 1, 8'h00); expect_st("tos09", 8'h09, 1, 1, 0, 0);
        op(0, 0, 0, 8'h00); expect_st("idle", 8'h09, 0, 1, 0, 0);
        op(0, 1, 0, 8'h00); expect_st("pop09", 8'h09, 1, 0, 0, 0);

        // Replace on empty bypasses d_in
        op(1, 1, 0, 8'h7E); expect_st("bypass7E", 8'h7E, 1, 0, 0, 0);

        // Asynchronous reset mid-cycle
        op(1, 0, 0, 8'h44); expect_st("p44", 8'h7E, 0, 1, 0, 0);
        op(1, 0, 0, 8'h55); expect_st("p55", 8'h7E, 0, 2, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        lat_ovf = 1'b0;
        lat_unf = 1'b0;
        expect_st("async_rst", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 0, 1, 8'h00); expect_st("tos_post_rst", 8'h00, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
